// File: rtl/fetcher.sv
// Instruction fetch stage: owns the PC, fetches words from memctrl, issues them to the dispatcher.
// Optional direct-mapped instruction cache enabled by defining FETCHER_ICACHE_EN.
module fetcher #(
  parameter int unsigned ICACHE_SIZE_LOG = 6,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic [31:0] pc_to_mc,
  output logic        ena_to_mc,
  output logic        drop_flag_to_mc,
  input  logic        ok_flag_from_mc,
  input  logic [31:0] inst_from_mc,
  input  logic        full_from_dsp,
  output logic        valid_to_dsp,
  output logic [31:0] inst_to_dsp,
  output logic [31:0] pc_to_dsp,
  input  logic        rollback_flag_from_rob,
  input  logic [31:0] target_pc_from_rob
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    READY    = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pending_inst, pending_inst_nxt;
  logic [31:0] pc_to_mc_nxt;
  logic        ena_to_mc_nxt;
  logic        drop_flag_nxt;
  logic        valid_to_dsp_nxt;
  logic [31:0] inst_to_dsp_nxt;
  logic [31:0] pc_to_dsp_nxt;

  logic        cache_hit;
  logic [31:0] cache_line;

`ifdef FETCHER_ICACHE_EN
  localparam int unsigned LINES = 2 ** ICACHE_SIZE_LOG;
  localparam int unsigned TAG_W = 32 - ICACHE_SIZE_LOG - 2;

  logic [LINES-1:0]           line_valid;
  logic [TAG_W-1:0]           line_tag  [LINES];
  logic [31:0]                line_data [LINES];
  logic [ICACHE_SIZE_LOG-1:0] cache_idx;
  logic [TAG_W-1:0]           cache_tag;
  logic                       cache_fill;

  assign cache_idx  = pc[ICACHE_SIZE_LOG+1:2];
  assign cache_tag  = pc[31:ICACHE_SIZE_LOG+2];
  assign cache_hit  = line_valid[cache_idx] && (line_tag[cache_idx] == cache_tag);
  assign cache_line = line_data[cache_idx];
  // Fill only from a response that is actually accepted (not cancelled by rollback).
  assign cache_fill = rdy && (state == WAIT_MEM) && ok_flag_from_mc && !rollback_flag_from_rob;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_valid <= '0;
    end else if (cache_fill) begin
      line_valid[cache_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_fill) begin
      line_tag[cache_idx]  <= cache_tag;
      line_data[cache_idx] <= inst_from_mc;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_line = 32'h0;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    pending_inst_nxt = pending_inst;
    pc_to_mc_nxt     = pc_to_mc;
    ena_to_mc_nxt    = 1'b0;
    drop_flag_nxt    = 1'b0;
    valid_to_dsp_nxt = 1'b0;
    inst_to_dsp_nxt  = inst_to_dsp;
    pc_to_dsp_nxt    = pc_to_dsp;

    if (rollback_flag_from_rob) begin
      pc_nxt        = target_pc_from_rob;
      drop_flag_nxt = 1'b1;
      state_nxt     = DROP;
    end else begin
      case (state)
        IDLE: begin
          if (!full_from_dsp) begin
            if (cache_hit) begin
              valid_to_dsp_nxt = 1'b1;
              inst_to_dsp_nxt  = cache_line;
              pc_to_dsp_nxt    = pc;
              pc_nxt           = pc + 32'd4;
            end else begin
              ena_to_mc_nxt = 1'b1;
              pc_to_mc_nxt  = pc;
              state_nxt     = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (ok_flag_from_mc) begin
            pending_inst_nxt = inst_from_mc;
            state_nxt        = READY;
          end
        end
        READY: begin
          if (!full_from_dsp) begin
            valid_to_dsp_nxt = 1'b1;
            inst_to_dsp_nxt  = pending_inst;
            pc_to_dsp_nxt    = pc;
            pc_nxt           = pc + 32'd4;
            state_nxt        = IDLE;
          end
        end
        DROP: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and output registers; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      pending_inst    <= 32'h0;
      pc_to_mc        <= 32'h0;
      ena_to_mc       <= 1'b0;
      drop_flag_to_mc <= 1'b0;
      valid_to_dsp    <= 1'b0;
      inst_to_dsp     <= 32'h0;
      pc_to_dsp       <= 32'h0;
    end else if (rdy) begin
      state           <= state_nxt;
      pc              <= pc_nxt;
      pending_inst    <= pending_inst_nxt;
      pc_to_mc        <= pc_to_mc_nxt;
      ena_to_mc       <= ena_to_mc_nxt;
      drop_flag_to_mc <= drop_flag_nxt;
      valid_to_dsp    <= valid_to_dsp_nxt;
      inst_to_dsp     <= inst_to_dsp_nxt;
      pc_to_dsp       <= pc_to_dsp_nxt;
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Directed testbench for fetcher: table of fetch transactions plus hand-written corner sequences.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_to_mc;
  logic        ena_to_mc;
  logic        drop_flag_to_mc;
  logic        ok_flag_from_mc;
  logic [31:0] inst_from_mc;
  logic        full_from_dsp;
  logic        valid_to_dsp;
  logic [31:0] inst_to_dsp;
  logic [31:0] pc_to_dsp;
  logic        rollback_flag_from_rob;
  logic [31:0] target_pc_from_rob;

  int n_checks  = 0;
  int n_fail    = 0;
  int ena_cnt   = 0;
  int drop_cnt  = 0;
  int valid_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          lat;
  } vec_t;

  vec_t tbl [8];

  fetcher #(.ICACHE_SIZE_LOG(6), .RESET_PC(32'h0)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rdy                   (rdy),
    .pc_to_mc              (pc_to_mc),
    .ena_to_mc             (ena_to_mc),
    .drop_flag_to_mc       (drop_flag_to_mc),
    .ok_flag_from_mc       (ok_flag_from_mc),
    .inst_from_mc          (inst_from_mc),
    .full_from_dsp         (full_from_dsp),
    .valid_to_dsp          (valid_to_dsp),
    .inst_to_dsp           (inst_to_dsp),
    .pc_to_dsp             (pc_to_dsp),
    .rollback_flag_from_rob(rollback_flag_from_rob),
    .target_pc_from_rob    (target_pc_from_rob)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and tally pulsed outputs seen there.
  task automatic step();
    @(negedge clk);
    if (ena_to_mc === 1'b1)       ena_cnt++;
    if (drop_flag_to_mc === 1'b1) drop_cnt++;
    if (valid_to_dsp === 1'b1)    valid_cnt++;
  endtask

  task automatic wait_ena(input string name, input logic [31:0] exp_pc);
    int n = 0;
    while (ena_to_mc !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({name, "_ena"}, 32'(ena_to_mc), 32'd1);
    check({name, "_pc_to_mc"}, pc_to_mc, exp_pc);
  endtask

  // Memctrl answers lat cycles after the request; issue follows two edges after ok.
  task automatic respond(input string name, input logic [31:0] exp_pc,
                         input logic [31:0] word, input int lat);
    repeat (lat - 1) step();
    ok_flag_from_mc = 1'b1;
    inst_from_mc    = word;
    step();
    ok_flag_from_mc = 1'b0;
    inst_from_mc    = 32'h0;
    step();
    check({name, "_valid"}, 32'(valid_to_dsp), 32'd1);
    check({name, "_pc_to_dsp"}, pc_to_dsp, exp_pc);
    check({name, "_inst"}, inst_to_dsp, word);
  endtask

  task automatic serve(input string name, input logic [31:0] exp_pc,
                       input logic [31:0] word, input int lat);
    wait_ena(name, exp_pc);
    respond(name, exp_pc, word, lat);
  endtask

  initial begin
    int base;
    tbl[0] = '{32'h00, 32'h00000013, 5};
    tbl[1] = '{32'h04, 32'h00100093, 1};
    tbl[2] = '{32'h08, 32'h00200113, 3};
    tbl[3] = '{32'h0C, 32'h00300193, 2};
    tbl[4] = '{32'h10, 32'h00400213, 4};
    tbl[5] = '{32'h14, 32'h00500293, 1};
    tbl[6] = '{32'h18, 32'h00600313, 2};
    tbl[7] = '{32'h1C, 32'h00700393, 3};

    rst = 1'b0;
    rdy = 1'b1;
    ok_flag_from_mc = 1'b0;
    inst_from_mc = 32'h0;
    full_from_dsp = 1'b0;
    rollback_flag_from_rob = 1'b0;
    target_pc_from_rob = 32'h0;

    repeat (2) step();
    check("reset_ena", 32'(ena_to_mc), 32'd0);
    check("reset_valid", 32'(valid_to_dsp), 32'd0);
    check("reset_drop", 32'(drop_flag_to_mc), 32'd0);
    check("reset_pc_to_mc", pc_to_mc, 32'h0);
    rst = 1'b1;

    // Cold pass over 0x00..0x1C, each word via memctrl.
    for (int i = 0; i < 8; i++) begin
      serve($sformatf("cold%0d", i), tbl[i].pc, tbl[i].word, tbl[i].lat);
    end

    // Rollback to 0 before the request for 0x20 goes out.
    rollback_flag_from_rob = 1'b1;
    target_pc_from_rob = 32'h0;
    step();
    rollback_flag_from_rob = 1'b0;
    check("loop_drop", 32'(drop_flag_to_mc), 32'd1);
    check("loop_drop_no_ena", 32'(ena_to_mc), 32'd0);
`ifdef FETCHER_ICACHE_EN
    step();
    check("hit_gap_valid", 32'(valid_to_dsp), 32'd0);
    base = ena_cnt;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("hit%0d_valid", i), 32'(valid_to_dsp), 32'd1);
      check($sformatf("hit%0d_pc", i), pc_to_dsp, tbl[i].pc);
      check($sformatf("hit%0d_inst", i), inst_to_dsp, tbl[i].word);
    end
    check("hit_pass_ena_count", 32'(ena_cnt - base), 32'd0);
    step();
    check("miss_after_hits_ena", 32'(ena_to_mc), 32'd1);
    check("miss_after_hits_pc", pc_to_mc, 32'h20);
`else
    for (int i = 0; i < 8; i++) begin
      serve($sformatf("warm%0d", i), tbl[i].pc, tbl[i].word, 1);
    end
    wait_ena("miss_after_loop", 32'h20);
`endif

    // Rollback during WAIT_MEM; stale ok lands in the DROP cycle.
    base = drop_cnt;
    rollback_flag_from_rob = 1'b1;
    target_pc_from_rob = 32'h100;
    step();
    rollback_flag_from_rob = 1'b0;
    check("wm_drop", 32'(drop_flag_to_mc), 32'd1);
    ok_flag_from_mc = 1'b1;
    inst_from_mc = 32'hDEADBEEF;
    step();
    ok_flag_from_mc = 1'b0;
    inst_from_mc = 32'h0;
    check("wm_stale_valid", 32'(valid_to_dsp), 32'd0);
    check("wm_idle_no_ena", 32'(ena_to_mc), 32'd0);
    step();
    check("wm_redirect_ena", 32'(ena_to_mc), 32'd1);
    check("wm_redirect_pc", pc_to_mc, 32'h100);
    check("wm_drop_count", 32'(drop_cnt - base), 32'd1);
    respond("redirect", 32'h100, 32'h00008067, 4);

    // 0x100 now owns the line of 0x0: refetch of 0x0 must miss.
    rollback_flag_from_rob = 1'b1;
    target_pc_from_rob = 32'h0;
    step();
    rollback_flag_from_rob = 1'b0;
    check("alias_drop", 32'(drop_flag_to_mc), 32'd1);
    wait_ena("alias", 32'h0);
    respond("alias", 32'h0, tbl[0].word, 2);

    // The stale word must not have been cached at 0x20.
    rollback_flag_from_rob = 1'b1;
    target_pc_from_rob = 32'h20;
    step();
    rollback_flag_from_rob = 1'b0;
    check("stale_drop", 32'(drop_flag_to_mc), 32'd1);
    wait_ena("stale", 32'h20);

    // Dispatcher full for 10 cycles in READY.
    full_from_dsp = 1'b1;
    ok_flag_from_mc = 1'b1;
    inst_from_mc = 32'h00A00093;
    step();
    ok_flag_from_mc = 1'b0;
    inst_from_mc = 32'h0;
    base = valid_cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("full%0d_valid", i), 32'(valid_to_dsp), 32'd0);
      check($sformatf("full%0d_ena", i), 32'(ena_to_mc), 32'd0);
    end
    full_from_dsp = 1'b0;
    step();
    check("full_release_valid", 32'(valid_to_dsp), 32'd1);
    check("full_release_pc", pc_to_dsp, 32'h20);
    check("full_release_inst", inst_to_dsp, 32'h00A00093);
    step();
    check("full_next_ena", 32'(ena_to_mc), 32'd1);
    check("full_next_pc", pc_to_mc, 32'h24);
    check("full_issue_count", 32'(valid_cnt - base), 32'd1);

    // rdy low freezes outputs and masks memctrl responses.
    rdy = 1'b0;
    ok_flag_from_mc = 1'b1;
    inst_from_mc = 32'h11111111;
    step();
    ok_flag_from_mc = 1'b0;
    inst_from_mc = 32'h0;
    check("rdy_hold_ena0", 32'(ena_to_mc), 32'd1);
    check("rdy_hold_pc", pc_to_mc, 32'h24);
    step();
    check("rdy_hold_ena1", 32'(ena_to_mc), 32'd1);
    rdy = 1'b1;
    step();
    check("rdy_resume_ena", 32'(ena_to_mc), 32'd0);
    respond("rdy", 32'h24, 32'h00B00113, 2);

    // Asynchronous reset in the middle of WAIT_MEM.
    wait_ena("rst_pre", 32'h28);
    #2 rst = 1'b0;
    #1;
    check("rst_async_ena", 32'(ena_to_mc), 32'd0);
    check("rst_async_pc_to_mc", pc_to_mc, 32'h0);
    check("rst_async_valid", 32'(valid_to_dsp), 32'd0);
    check("rst_async_inst", inst_to_dsp, 32'h0);
    check("rst_async_pc_to_dsp", pc_to_dsp, 32'h0);
    step();
    rst = 1'b1;
    serve("rst_post", 32'h0, 32'h00000013, 3);
    wait_ena("rst_cold", 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction fetch stage, directly upstream of the memory controller: owns the PC, requests 32-bit instruction words over the controller's fetch port, and hands them one at a time to the dispatcher. Holds a direct-mapped instruction cache so that hits bypass the memory controller. A rollback from the ROB redirects the PC and cancels any in-flight fetch via the controller's drop flag.

## Interface
- `ICACHE_SIZE_LOG`, 6, log2 of cache lines (one 32-bit word per line)
- `RESET_PC`, 32'h0, PC after reset
- `clk` input 1 system clock, rising edge
- `rst` input 1 asynchronous, active-low reset
- `rdy` input 1 global enable; low freezes all state and outputs
- `pc_to_mc` output 32 fetch address to memctrl
- `ena_to_mc` output 1 one-cycle fetch request pulse
- `drop_flag_to_mc` output 1 one-cycle cancel of in-flight/buffered fetch and loads
- `ok_flag_from_mc` input 1 one-cycle pulse: `inst_from_mc` valid
- `inst_from_mc` input 32 fetched word, little-endian assembled
- `full_from_dsp` input 1 dispatcher cannot accept an instruction this cycle
- `valid_to_dsp` output 1 one-cycle pulse: instruction issued
- `inst_to_dsp` output 32 issued instruction
- `pc_to_dsp` output 32 PC of issued instruction
- `rollback_flag_from_rob` input 1 redirect request
- `target_pc_from_rob` input 32 redirect PC

## Operation
- States: IDLE, WAIT_MEM, READY, DROP. Registers: `pc`, `pending_inst`.
- Reset (`rst`=0, async): state IDLE, `pc`=RESET_PC, all outputs 0, all cache valid bits 0.
- `rdy`=0: nothing changes, outputs hold.
- Pulsed outputs (`ena_to_mc`, `drop_flag_to_mc`, `valid_to_dsp`) default 0 every enabled cycle.
- IDLE, `full_from_dsp`=0: on cache hit at `pc` issue directly (`valid_to_dsp`=1, `inst_to_dsp`=line, `pc_to_dsp`=`pc`), `pc`<=`pc`+4, stay IDLE. On miss: `ena_to_mc`=1, `pc_to_mc`=`pc`, -> WAIT_MEM. With `full_from_dsp`=1: do nothing.
- WAIT_MEM: `ena_to_mc` stays 0. On `ok_flag_from_mc`: `pending_inst`<=`inst_from_mc`, fill cache line, -> READY.
- READY: when `full_from_dsp`=0 issue `pending_inst` at `pc`, `pc`<=`pc`+4, -> IDLE.
- Rollback (any state, highest priority): `pc`<=`target_pc_from_rob`, `drop_flag_to_mc`=1, no issue, -> DROP. An `ok_flag_from_mc` in the same cycle is ignored (no fill, no issue).
- DROP: one cycle, no request, no issue; any `ok_flag_from_mc` ignored; -> IDLE. Guarantees no new request coincides with the drop.
- `ok_flag_from_mc` in IDLE or READY: ignored.
- Cache index `pc[ICACHE_SIZE_LOG+1:2]`, tag `pc[31:ICACHE_SIZE_LOG+2]`; fill writes valid, tag, data. No invalidation besides reset (no self-modifying code).
- PC arithmetic mod 2^32; `pc[1:0]` assumed 0 and not checked.
- No branch prediction: next PC is always `pc`+4 until rollback.

## Timing
- Hit: request in cycle T, `valid_to_dsp` registered high in T+1; sustained 1 instr/cycle.
- Miss: `ena_to_mc` high T+1; WAIT_MEM until ok pulse at M; READY at M+1; issue at M+1 edge, `valid_to_dsp` high M+2 if not full.
- Rollback at T: `drop_flag_to_mc` high T+1, DROP at T+1, IDLE at T+2, earliest new `ena_to_mc` T+3.
- `full_from_dsp` sampled combinationally in the deciding cycle.

## Configuration
- `FETCHER_ICACHE_EN` defined: cache as above.
- Undefined: no cache storage; every IDLE cycle with `full_from_dsp`=0 is a miss (READY path only); max throughput one instruction per memctrl round-trip. Interface identical.

## Test plan
- Reset, release, `rdy`=1, memctrl model returns 32'h00000013 after 5 cycles -> `pc_to_mc`=0, one `ena_to_mc` pulse, `valid_to_dsp` with `pc_to_dsp`=0, inst 32'h00000013; next request `pc_to_mc`=4.
- Straight loop 0..0x1C twice, then rollback to 0 -> second pass all hits (with macro): 8 issues in 8 consecutive cycles, no `ena_to_mc`.
- Rollback to 32'h100 during WAIT_MEM, late ok arrives during DROP -> exactly one `drop_flag_to_mc` pulse, stale word not issued or cached, next `pc_to_mc`=32'h100.
- `full_from_dsp` held high 10 cycles in READY with inst 32'h00A00093 -> no issue, `pc` frozen; drop full -> single issue, `pc`+4.
- Aliasing: fill 0x0 then 0x100 (ICACHE_SIZE_LOG=6) -> refetch of 0x0 misses and issues memctrl request.
- `rst` pulsed low mid-WAIT_MEM -> outputs 0 immediately, `pc`=RESET_PC, cache empty.
